delay_stats: RTL and testbench
==============================

# delay_stats

Downstream consumer of the delay-measurement stage. It captures each 16-bit elapsed-time result on the rising edge of that stage's `ready` strobe and accumulates min, max, sum and mean over a fixed window of samples. It presents one report per window on a valid/ready handshake to the readout logic (UART or host interface).

## Interface
- `LOG2_WINDOW`, default 4: window size is 2**LOG2_WINDOW samples; legal range 0..12.
- `SUM_W`, default 32: sum width; must be ≥ 16+LOG2_WINDOW, so the sum cannot overflow.
- `clk` in 1: single clock. All logic is on its rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `meas_number` in 16: measured edge count, stable while `meas_ready` is high.
- `meas_ready` in 1: level strobe from the measurement stage. One sample is taken per rising edge.
- `clear` in 1: synchronous one-cycle pulse. Aborts the current window and clears `overrun`.
- `rpt_valid` out 1: report available.
- `rpt_ready` in 1: consumer accepts the report.
- `rpt_min` out 16: minimum sample in the window.
- `rpt_max` out 16: maximum sample in the window.
- `rpt_sum` out SUM_W: sum of the window's samples.
- `rpt_mean` out 16: `rpt_sum >> LOG2_WINDOW` (truncated).
- `overrun` out 1: sticky flag; a completed window was dropped.

## Operation
- Edge detect: `ready_q` register; `edge = meas_ready & ~ready_q`.
- `ready_q` resets to 1, so a strobe already high at reset release is ignored.
- FSM states:
  - ACCUM: on `edge`, fold `meas_number` into the accumulators and increment `cnt`. If `cnt` reaches 2**LOG2_WINDOW−1 before the increment, go to FLUSH.
  - FLUSH, one cycle: transfer the accumulators to the report registers, reset the accumulators, return to ACCUM.
- Accumulator reset values: min=16'hFFFF, max=0, sum=0, `cnt`=0.
- Report transfer in FLUSH:
  - If `rpt_valid`=0, or `rpt_valid & rpt_ready` in this same cycle: load the report registers and set `rpt_valid`=1.
  - Otherwise: discard the new window, keep the old report, set `overrun`=1.
- Handshake: `rpt_valid` stays high until a cycle with `rpt_ready`=1. The report registers are stable while `rpt_valid`=1. `rpt_valid` then deasserts unless FLUSH reloads in the same cycle.
- `clear`:
  - Resets the accumulators and `cnt`, forces the state to ACCUM, clears `overrun`.
  - Does not touch a pending report.
  - Wins over a simultaneous `edge` (that sample is discarded) and over FLUSH (that window is discarded, no overrun).
- Arithmetic: the sum adds `meas_number` zero-extended to SUM_W. Min/max comparisons are unsigned. 16'hDEAD is treated as an ordinary value.

## Timing
- Reset values: `rpt_valid`=0, `overrun`=0, `rpt_min`=0, `rpt_max`=0, `rpt_sum`=0, `rpt_mean`=0; state=ACCUM.
- A sample is accumulated at the clock edge where `meas_ready`=1 and `ready_q`=0.
- Report latency: `rpt_valid` rises 2 edges after the edge that samples the window's last `meas_ready` rising level (accumulate edge, then FLUSH edge).
- Rising strobe edges are at least 2 cycles apart (high, low, high), so no edge can coincide with FLUSH. An `edge` seen in FLUSH is still accumulated into the fresh window.
- Reset asserted mid-window or mid-handshake: everything returns to reset values on the next edge. The partial window and any pending report are lost.

## Configuration
- `DELAY_STATS_MINMAX_EN`:
  - Defined: min/max comparators and registers are built as above.
  - Undefined: no comparators; `rpt_min` and `rpt_max` are tied to 0; sum, mean, handshake and overrun are unchanged.

## Structure
- Shared package `delay_pkg`:
  - `MEAS_W`=16.
  - FSM state enum (ACCUM, FLUSH).
  - Accumulator reset constants (`MIN_INIT`=16'hFFFF).
- One sub-module, `delay_stats_acc`: the min/max/sum/count accumulator with `clear`, `add` and `take` controls. The top level holds the edge detect, FSM, report registers and handshake.

## Test plan
- LOG2_WINDOW=2; strobes with 10, 3, 7, 20 and `rpt_ready`=1 → one report: min=3, max=20, sum=40, mean=10; `rpt_valid` high exactly 1 cycle, 2 edges after the 4th strobe.
- `meas_ready` held high through reset release, then 4 strobes of 5 → report sum=20 (the initial high is not counted).
- `rpt_ready`=0 across two full windows → first report held unchanged, `overrun`=1; then `rpt_ready`=1 → first report accepted, `rpt_valid`=0.
- Window completes in the same cycle the old report is accepted → new report loads, `rpt_valid` stays 1, `overrun`=0.
- Two samples, then `clear` coincident with the third strobe, then 4 strobes of 1 → report sum=4, min=max=1; `overrun` cleared.
- LOG2_WINDOW=4, sixteen samples of 16'hFFFF → sum=0x000FFFF0, mean=16'hFFFF, no overflow. The build without `DELAY_STATS_MINMAX_EN` gives min=max=0.

Source files
------------

// File: rtl/delay_pkg.sv
// delay_pkg: shared widths, FSM state and accumulator reset constants for delay_stats.
package delay_pkg;
    localparam int MEAS_W = 16;
    localparam logic [MEAS_W-1:0] MIN_INIT = 16'hFFFF;
    localparam logic [MEAS_W-1:0] MAX_INIT = 16'h0000;
    typedef enum logic {ACCUM, FLUSH} state_t;
endpackage

// File: rtl/delay_stats_acc.sv
// delay_stats_acc: running min/max/sum/count over one window of samples.
// Min/max registers exist only when DELAY_STATS_MINMAX_EN is defined; otherwise they read as 0.
module delay_stats_acc
    import delay_pkg::*;
#(
    parameter int LOG2_WINDOW = 4,
    parameter int SUM_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    input  logic              i_add,
    input  logic              i_take,
    input  logic [MEAS_W-1:0] i_data,
    output logic [MEAS_W-1:0] o_min,
    output logic [MEAS_W-1:0] o_max,
    output logic [SUM_W-1:0]  o_sum,
    output logic              o_last
);
    localparam int CW = (LOG2_WINDOW > 0) ? LOG2_WINDOW : 1;
    localparam logic [CW-1:0] LAST = CW'((2 ** LOG2_WINDOW) - 1);
    logic [CW-1:0]    r_cnt;
    logic [SUM_W-1:0] r_sum;
    logic             w_init;
    assign w_init = ~i_rst_n | i_clear | (i_take & ~i_add);
    // take restarts the window; a coincident add becomes the first sample of the new one
    always_ff @(posedge i_clk) begin
        if (w_init) begin
            r_sum <= '0;
            r_cnt <= '0;
        end else if (i_add) begin
            r_sum <= (i_take ? '0 : r_sum) + SUM_W'(i_data);
            r_cnt <= (i_take ? '0 : r_cnt) + CW'(1);
        end
    end
    assign o_sum  = r_sum;
    assign o_last = (r_cnt == LAST);
`ifdef DELAY_STATS_MINMAX_EN
    logic [MEAS_W-1:0] r_min, r_max, w_min_b, w_max_b;
    assign w_min_b = i_take ? MIN_INIT : r_min;
    assign w_max_b = i_take ? MAX_INIT : r_max;
    always_ff @(posedge i_clk) begin
        if (w_init) begin
            r_min <= MIN_INIT;
            r_max <= MAX_INIT;
        end else if (i_add) begin
            r_min <= (i_data < w_min_b) ? i_data : w_min_b;
            r_max <= (i_data > w_max_b) ? i_data : w_max_b;
        end
    end
    assign o_min = r_min;
    assign o_max = r_max;
`else
    assign o_min = '0;
    assign o_max = '0;
`endif
endmodule

// File: rtl/delay_stats.sv
// delay_stats: windowed min/max/sum/mean of delay measurements, one report per window on valid/ready.
// Min/max tracking is built only when DELAY_STATS_MINMAX_EN is defined.
module delay_stats
    import delay_pkg::*;
#(
    parameter int LOG2_WINDOW = 4,
    parameter int SUM_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [MEAS_W-1:0] i_meas_number,
    input  logic              i_meas_ready,
    input  logic              i_clear,
    output logic              o_rpt_valid,
    input  logic              i_rpt_ready,
    output logic [MEAS_W-1:0] o_rpt_min,
    output logic [MEAS_W-1:0] o_rpt_max,
    output logic [SUM_W-1:0]  o_rpt_sum,
    output logic [MEAS_W-1:0] o_rpt_mean,
    output logic              o_overrun
);
    state_t            r_state, w_next;
    logic              r_ready_q, r_valid, r_overrun;
    logic              w_edge, w_last, w_take, w_load, w_drop;
    logic [MEAS_W-1:0] w_acc_min, w_acc_max, r_min, r_max;
    logic [SUM_W-1:0]  w_acc_sum, r_sum;
    // reset high so a strobe already asserted at reset release is not counted
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_ready_q <= 1'b1;
        else          r_ready_q <= i_meas_ready;
    end
    assign w_edge = i_meas_ready & ~r_ready_q;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= ACCUM;
        else          r_state <= w_next;
    end
    always_comb begin
        w_next = (i_clear || r_state == FLUSH) ? ACCUM : (w_edge && w_last) ? FLUSH : ACCUM;
    end
    always_comb begin
        w_take = (r_state == FLUSH);
        w_load = w_take & ~i_clear & (~r_valid | i_rpt_ready);
        w_drop = w_take & ~i_clear & r_valid & ~i_rpt_ready;
    end
    delay_stats_acc #(.LOG2_WINDOW(LOG2_WINDOW), .SUM_W(SUM_W)) u_acc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (i_clear),
        .i_add   (w_edge),
        .i_take  (w_take),
        .i_data  (i_meas_number),
        .o_min   (w_acc_min),
        .o_max   (w_acc_max),
        .o_sum   (w_acc_sum),
        .o_last  (w_last)
    );
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_sum     <= '0;
            r_min     <= '0;
            r_max     <= '0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_sum   <= w_acc_sum;
                r_min   <= w_acc_min;
                r_max   <= w_acc_max;
            end else if (i_rpt_ready) begin
                r_valid <= 1'b0;
            end
            r_overrun <= ~i_clear & (r_overrun | w_drop);
        end
    end
    assign o_rpt_valid = r_valid;
    assign o_rpt_min   = r_min;
    assign o_rpt_max   = r_max;
    assign o_rpt_sum   = r_sum;
    assign o_rpt_mean  = r_sum[LOG2_WINDOW +: MEAS_W];
    assign o_overrun   = r_overrun;
endmodule

// File: tb/tb_delay_stats.sv
// tb_delay_stats: table-driven windows plus handshake/overrun/clear/reset sequences, scoreboarded reports.
module tb_delay_stats;
    logic        clk = 1'b0, rst_n = 1'b0, mr = 1'b0, clr = 1'b0, rr = 1'b1;
    logic [15:0] mn = '0;
    logic        v, ov;
    logic [15:0] mi, ma, me;
    logic [31:0] su;
    logic        mr4 = 1'b0, clr4 = 1'b0, rr4 = 1'b1;
    logic [15:0] mn4 = '0;
    logic        v4, ov4;
    logic [15:0] mi4, ma4, me4;
    logic [31:0] su4;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    delay_stats #(.LOG2_WINDOW(2), .SUM_W(32)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_meas_number(mn), .i_meas_ready(mr), .i_clear(clr),
        .o_rpt_valid(v), .i_rpt_ready(rr), .o_rpt_min(mi), .o_rpt_max(ma), .o_rpt_sum(su),
        .o_rpt_mean(me), .o_overrun(ov)
    );
    delay_stats #(.LOG2_WINDOW(4), .SUM_W(32)) u_dut16 (
        .i_clk(clk), .i_rst_n(rst_n), .i_meas_number(mn4), .i_meas_ready(mr4), .i_clear(clr4),
        .o_rpt_valid(v4), .i_rpt_ready(rr4), .o_rpt_min(mi4), .o_rpt_max(ma4), .o_rpt_sum(su4),
        .o_rpt_mean(me4), .o_overrun(ov4)
    );

    typedef struct {logic [15:0] mn; logic [15:0] mx; logic [31:0] sum; logic [15:0] mean;} rpt_t;
    typedef struct {logic [3:0][15:0] s; rpt_t r;} vec_t;
    rpt_t q[$];
    vec_t tbl[4];

    function automatic rpt_t mk(input logic [15:0] mn_e, input logic [15:0] mx_e,
                                input logic [31:0] sum_e, input logic [15:0] mean_e);
        rpt_t r;
`ifdef DELAY_STATS_MINMAX_EN
        r.mn = mn_e;
        r.mx = mx_e;
`else
        r.mn = '0;
        r.mx = '0;
`endif
        r.sum  = sum_e;
        r.mean = mean_e;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic strobe(input logic [15:0] d, input logic c);
        @(posedge clk); #1 mr = 1'b1; mn = d; clr = c;
        @(posedge clk); #1 mr = 1'b0; clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard: every accepted report must match the oldest expected one
    always @(negedge clk) begin
        rpt_t e;
        if (rst_n && v && rr) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_report: sum %0h with empty scoreboard", su);
            end else begin
                e = q.pop_front();
                chk("rpt_min", {16'h0, mi}, {16'h0, e.mn});
                chk("rpt_max", {16'h0, ma}, {16'h0, e.mx});
                chk("rpt_sum", su, e.sum);
                chk("rpt_mean", {16'h0, me}, {16'h0, e.mean});
            end
        end
    end

    initial begin
        int n;
        tbl[0].s = {16'd20, 16'd7, 16'd3, 16'd10};
        tbl[0].r = mk(16'd3, 16'd20, 32'd40, 16'd10);
        tbl[1].s = {16'd0, 16'd0, 16'd0, 16'd0};
        tbl[1].r = mk(16'd0, 16'd0, 32'd0, 16'd0);
        tbl[2].s = {16'd2, 16'hDEAD, 16'd1, 16'hFFFF};
        tbl[2].r = mk(16'd1, 16'hFFFF, 32'h0001DEAF, 16'h77AB);
        tbl[3].s = {16'd400, 16'd300, 16'd200, 16'd100};
        tbl[3].r = mk(16'd100, 16'd400, 32'd1000, 16'd250);

        // strobe held high through reset release must not count
        mr = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_valid", v, 0);
        chk("reset_overrun", ov, 0);
        chk("reset_min", mi, 0);
        chk("reset_max", ma, 0);
        chk("reset_sum", su, 0);
        chk("reset_mean", me, 0);
        idle(2);
        mr = 1'b0;
        q.push_back(mk(16'd5, 16'd5, 32'd20, 16'd5));
        repeat (4) strobe(16'd5, 1'b0);
        idle(3);

        // first window also checks latency and one-cycle valid
        q.push_back(tbl[0].r);
        for (int i = 0; i < 4; i++) strobe(tbl[0].s[i], 1'b0);
        chk("lat_edge0", v, 0);
        idle(1);
        chk("lat_edge1", v, 1);
        idle(1);
        chk("lat_edge2", v, 0);
        for (int k = 1; k < 4; k++) begin
            q.push_back(tbl[k].r);
            for (int i = 0; i < 4; i++) strobe(tbl[k].s[i], 1'b0);
            idle(3);
        end

        // two windows without acceptance: first held, second dropped
        rr = 1'b0;
        q.push_back(mk(16'd11, 16'd44, 32'd110, 16'd27));
        strobe(16'd11, 1'b0); strobe(16'd22, 1'b0); strobe(16'd33, 1'b0); strobe(16'd44, 1'b0);
        repeat (4) strobe(16'd1, 1'b0);
        idle(3);
        chk("ovr_flag", ov, 1);
        chk("ovr_valid", v, 1);
        chk("ovr_held_sum", su, 32'd110);
        chk("ovr_held_mean", me, 16'd27);
        rr = 1'b1;
        idle(1);
        chk("ovr_accept_valid", v, 0);
        chk("ovr_sticky", ov, 1);

        // clear with a coincident strobe discards the partial window and overrun
        strobe(16'd50, 1'b0);
        strobe(16'd60, 1'b0);
        strobe(16'd70, 1'b1);
        chk("clear_overrun", ov, 0);
        q.push_back(mk(16'd1, 16'd1, 32'd4, 16'd1));
        repeat (4) strobe(16'd1, 1'b0);
        idle(3);

        // new window completes in the same cycle the pending report is accepted
        rr = 1'b0;
        q.push_back(mk(16'd2, 16'd8, 32'd20, 16'd5));
        q.push_back(mk(16'd9, 16'd9, 32'd36, 16'd9));
        strobe(16'd2, 1'b0); strobe(16'd4, 1'b0); strobe(16'd6, 1'b0); strobe(16'd8, 1'b0);
        idle(2);
        repeat (4) strobe(16'd9, 1'b0);
        rr = 1'b1;
        idle(1);
        rr = 1'b0;
        chk("sim_valid", v, 1);
        chk("sim_overrun", ov, 0);
        chk("sim_sum", su, 32'd36);
        rr = 1'b1;
        idle(2);
        chk("sim_done_valid", v, 0);

        // reset mid-handshake and mid-window loses everything
        rr = 1'b0;
        repeat (4) strobe(16'd3, 1'b0);
        repeat (2) strobe(16'd7, 1'b0);
        rst_n = 1'b0;
        idle(1);
        chk("midrst_valid", v, 0);
        chk("midrst_sum", su, 0);
        rst_n = 1'b1;
        rr = 1'b1;
        q.push_back(mk(16'd2, 16'd2, 32'd8, 16'd2));
        repeat (4) strobe(16'd2, 1'b0);
        idle(3);

        // 16-sample window of all-ones on the LOG2_WINDOW=4 instance
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1 mr4 = 1'b1; mn4 = 16'hFFFF;
            @(posedge clk); #1 mr4 = 1'b0;
        end
        rr4 = 1'b0;
        n = 0;
        while (!v4 && n < 10) begin
            idle(1);
            n++;
        end
        chk("w16_valid", v4, 1);
        chk("w16_sum", su4, 32'h000FFFF0);
        chk("w16_mean", me4, 16'hFFFF);
`ifdef DELAY_STATS_MINMAX_EN
        chk("w16_min", mi4, 16'hFFFF);
        chk("w16_max", ma4, 16'hFFFF);
`else
        chk("w16_min", mi4, 16'h0);
        chk("w16_max", ma4, 16'h0);
`endif
        chk("w16_overrun", ov4, 0);

        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
